// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
//
// Two-master / one-slave AXI4-Lite read-channel arbiter in front of the shared
// SRAM read port. Master 0 is the instruction-fetch unit (IFU) and master 1 is
// the load/store unit (LSU). Only one read is in flight at a time. When both
// masters request in the same IDLE cycle, the master that was not served last
// wins. A watchdog answers the owning master with SLVERR if the slave never
// returns read data.
//
// Transaction flow: IDLE (arbitrate) -> ADDR (forward AR) -> DATA (forward R)
// -> IDLE, or DATA -> ERR (synthesised SLVERR) -> IDLE when the watchdog
// expires. The minimum IDLE-to-IDLE time is three cycles.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   m0_* (IFU), m1_* (LSU)   araddr/arvalid/arready and rdata/rresp/rvalid/rready
//                            of each master's AXI4-Lite read channel
//   s_*                      read channel towards the SRAM slave
//   busy                     high whenever a transaction is in progress
//   grant_id                 owner of the current transaction (0 IFU, 1 LSU)
//   late_drop                one-cycle pulse after a slave response that
//                            arrived in IDLE was discarded
//
// Parameters
//   AW, DW     address / data width
//   TIMEOUT    DATA-state cycles to wait for s_rvalid; 0 disables the watchdog
// -----------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] m0_araddr,
    input  logic          m0_arvalid,
    output logic          m0_arready,
    output logic [DW-1:0] m0_rdata,
    output logic [1:0]    m0_rresp,
    output logic          m0_rvalid,
    input  logic          m0_rready,

    input  logic [AW-1:0] m1_araddr,
    input  logic          m1_arvalid,
    output logic          m1_arready,
    output logic [DW-1:0] m1_rdata,
    output logic [1:0]    m1_rresp,
    output logic          m1_rvalid,
    input  logic          m1_rready,

    output logic [AW-1:0] s_araddr,
    output logic          s_arvalid,
    input  logic          s_arready,
    input  logic [DW-1:0] s_rdata,
    input  logic [1:0]    s_rresp,
    input  logic          s_rvalid,
    output logic          s_rready,

    output logic          busy,
    output logic          grant_id,
    output logic          late_drop
);

    // A zero-width counter is illegal, so a disabled watchdog keeps one bit.
    localparam int            CW          = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD    = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST    = CW'(1);
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR
    } state_e;

    state_e        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;       // master served by the last completed read
    logic [CW-1:0] cnt_q, cnt_d;         // watchdog; holds 0 outside DATA
    logic          late_q, late_d;

    logic          sel_rready;

    assign sel_rready = grant_q ? m1_rready : m0_rready;

    assign busy      = (state_q != ST_IDLE);
    assign grant_id  = grant_q;
    assign late_drop = late_q;

    // NOTE: every signal written here receives a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        late_d     = 1'b0;

        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;

        // The address mux runs continuously; it is only qualified in ADDR.
        s_araddr   = grant_q ? m1_araddr : m0_araddr;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Always accept so a stray late response cannot wedge the slave.
                s_rready = 1'b1;
                late_d   = s_rvalid;
                if (m0_arvalid || m1_arvalid) begin
                    state_d = ST_ADDR;
                    if (m0_arvalid && m1_arvalid) begin
                        grant_d = ~last_q;
                    end else begin
                        grant_d = m1_arvalid;
                    end
                end
            end

            ST_ADDR: begin
                s_arvalid = 1'b1;
                if (grant_q) begin
                    m1_arready = s_arready;
                end else begin
                    m0_arready = s_arready;
                end
                if (s_arready) begin
                    state_d = ST_DATA;
                    cnt_d   = CNT_LOAD;
                end
            end

            ST_DATA: begin
                s_rready = sel_rready;
                if (grant_q) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                end
                // A handshake in the expiry cycle still completes normally.
                if (s_rvalid && sel_rready) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                    cnt_d   = '0;
                end else if (TIMEOUT != 0) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_ERR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - CNT_LAST;
                    end
                end
            end

            ST_ERR: begin
                // Slave is not read here; its eventual answer is dropped in IDLE.
                if (grant_q) begin
                    m1_rvalid = 1'b1;
                    m1_rresp  = RESP_SLVERR;
                end else begin
                    m0_rvalid = 1'b1;
                    m0_rresp  = RESP_SLVERR;
                end
                if (sel_rready) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            late_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            late_q  <= late_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter
//
// Self-checking bench for axi_rd_arbiter. Two instances share all inputs: dut
// (TIMEOUT=16) for normal traffic and dut_to (TIMEOUT=4) for the watchdog.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
// The randomized test predicts the service order (round robin on a tie) and
// the returned data from a transaction-level model.
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic [AW-1:0] m0_araddr  = '0;
    logic          m0_arvalid = 1'b0;
    logic          m0_rready  = 1'b0;
    logic [AW-1:0] m1_araddr  = '0;
    logic          m1_arvalid = 1'b0;
    logic          m1_rready  = 1'b0;
    logic          s_arready  = 1'b0;
    logic [DW-1:0] s_rdata    = '0;
    logic [1:0]    s_rresp    = 2'b00;
    logic          s_rvalid   = 1'b0;

    logic          m0_arready, m0_rvalid, m1_arready, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [1:0]    m0_rresp, m1_rresp;
    logic [AW-1:0] s_araddr;
    logic          s_arvalid, s_rready, busy, grant_id, late_drop;

    logic          to_m0_arready, to_m0_rvalid, to_m1_arready, to_m1_rvalid;
    logic [DW-1:0] to_m0_rdata, to_m1_rdata;
    logic [1:0]    to_m0_rresp, to_m1_rresp;
    logic [AW-1:0] to_s_araddr;
    logic          to_s_arvalid, to_s_rready, to_busy, to_grant_id, to_late_drop;

    int n_checks = 0;
    int n_fail   = 0;
    bit sel_to   = 1'b0;   // handshake tracking follows dut_to instead of dut

    axi_rd_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .busy(busy), .grant_id(grant_id), .late_drop(late_drop)
    );

    axi_rd_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(to_m0_arready),
        .m0_rdata(to_m0_rdata), .m0_rresp(to_m0_rresp), .m0_rvalid(to_m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(to_m1_arready),
        .m1_rdata(to_m1_rdata), .m1_rresp(to_m1_rresp), .m1_rvalid(to_m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(to_s_araddr), .s_arvalid(to_s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(to_s_rready),
        .busy(to_busy), .grant_id(to_grant_id), .late_drop(to_late_drop)
    );

    always #5 clk = ~clk;

    // Slave memory model: data and response are pure functions of the address.
    function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [1:0] slave_resp(input logic [AW-1:0] a);
        return a[3] ? 2'b10 : 2'b00;
    endfunction

    // Called at negedge: note handshakes, advance to posedge+1, retire the
    // master/slave valids that just handshook.
    task automatic next_cycle();
        logic d0, d1, ds;
        d0 = m0_arvalid && (sel_to ? to_m0_arready : m0_arready);
        d1 = m1_arvalid && (sel_to ? to_m1_arready : m1_arready);
        ds = s_rvalid   && (sel_to ? to_s_rready   : s_rready);
        @(posedge clk);
        #1;
        if (d0) m0_arvalid = 1'b0;
        if (d1) m1_arvalid = 1'b0;
        if (ds) begin
            s_rvalid = 1'b0;
            s_rdata  = '0;
            s_rresp  = 2'b00;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        m0_arvalid = 1'b0; m0_araddr = '0; m0_rready = 1'b0;
        m1_arvalid = 1'b0; m1_araddr = '0; m1_rready = 1'b0;
        s_arready  = 1'b0; s_rvalid  = 1'b0; s_rdata = '0; s_rresp = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        @(posedge clk);
        #1;
        v = {busy, grant_id, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, late_drop};
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reset_outputs: got %b want 00000000", v); end
        v = {to_busy, to_grant_id, to_m0_arready, to_m1_arready, to_m0_rvalid, to_m1_rvalid, to_s_arvalid, to_late_drop};
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reset_outputs_to: got %b want 00000000", v); end
        n_checks++;
        if (s_rready !== 1'b1) begin n_fail++; $display("FAIL reset_rready: got %b want 1", s_rready); end
        rst = 1'b0;
    endtask

    task automatic test_ifu_single();
        do_reset();
        m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1; m0_rready = 1'b1; s_arready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({m0_arready, s_arvalid, busy} !== 3'b000) begin
            n_fail++; $display("FAIL t1_arb_latency: got %b want 000", {m0_arready, s_arvalid, busy});
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({s_arvalid, m0_arready, m1_arready, busy, grant_id} !== 5'b11010) begin
            n_fail++; $display("FAIL t1_addr_phase: got %b want 11010", {s_arvalid, m0_arready, m1_arready, busy, grant_id});
        end
        n_checks++;
        if (s_araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL t1_araddr: got %h want 80000000", s_araddr); end
        next_cycle();
        s_rvalid = 1'b1; s_rdata = 32'h0000_0413; s_rresp = 2'b00;
        @(negedge clk);
        n_checks++;
        if ({m0_rvalid, m1_rvalid, s_rready} !== 3'b101) begin
            n_fail++; $display("FAIL t1_r_valid: got %b want 101", {m0_rvalid, m1_rvalid, s_rready});
        end
        n_checks++;
        if ({m0_rdata, m0_rresp} !== {32'h0000_0413, 2'b00}) begin
            n_fail++; $display("FAIL t1_rdata: got %h/%b want 00000413/00", m0_rdata, m0_rresp);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({busy, m0_rvalid} !== 2'b00) begin n_fail++; $display("FAIL t1_busy_end: got %b want 00", {busy, m0_rvalid}); end
    endtask

    task automatic test_tie_round_robin();
        logic [AW-1:0] a [2];
        do_reset();
        m0_rready = 1'b1; m1_rready = 1'b1; s_arready = 1'b1;
        // Tie from reset, then the held LSU request, then a second tie.
        for (int k = 0; k < 4; k++) begin
            int e;
            e = k % 2;
            if (e == 0) begin
                a[0] = $urandom & 32'hFFFF_FFFC;
                a[1] = $urandom & 32'hFFFF_FFFC;
                m0_araddr = a[0]; m1_araddr = a[1];
                m0_arvalid = 1'b1; m1_arvalid = 1'b1;
            end
            @(negedge clk);
            next_cycle();
            @(negedge clk);
            n_checks++;
            if (grant_id !== e[0]) begin n_fail++; $display("FAIL t2_grant k=%0d: got %b want %0d", k, grant_id, e); end
            n_checks++;
            if (s_araddr !== a[e]) begin n_fail++; $display("FAIL t2_araddr k=%0d: got %h want %h", k, s_araddr, a[e]); end
            n_checks++;
            if ({m0_arready, m1_arready} !== ((e == 0) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL t2_arready k=%0d: got %b", k, {m0_arready, m1_arready});
            end
            next_cycle();
            s_rvalid = 1'b1; s_rdata = slave_data(a[e]); s_rresp = 2'b00;
            @(negedge clk);
            n_checks++;
            if ({m0_rvalid, m1_rvalid} !== ((e == 0) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL t2_rvalid k=%0d: got %b", k, {m0_rvalid, m1_rvalid});
            end
            n_checks++;
            if (((e == 0) ? {m0_rdata, m1_rdata} : {m1_rdata, m0_rdata}) !== {slave_data(a[e]), 32'h0}) begin
                n_fail++; $display("FAIL t2_rdata k=%0d: got m0=%h m1=%h want %h on m%0d only", k, m0_rdata, m1_rdata, slave_data(a[e]), e);
            end
            next_cycle();
        end
    endtask

    task automatic test_lsu_waits();
        do_reset();
        m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
        m0_rready = 1'b1; m1_rready = 1'b1; s_arready = 1'b1;
        @(negedge clk); next_cycle();
        @(negedge clk); next_cycle();
        m1_araddr = 32'h8000_1000; m1_arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({m1_arready, m0_rvalid, m1_rvalid, grant_id, busy} !== 5'b00001) begin
                n_fail++; $display("FAIL t3_lsu_blocked i=%0d: got %b want 00001", i, {m1_arready, m0_rvalid, m1_rvalid, grant_id, busy});
            end
            next_cycle();
        end
        s_rvalid = 1'b1; s_rdata = 32'hCAFE_0001;
        @(negedge clk);
        n_checks++;
        if ({m0_rvalid, m1_arready, m0_rdata} !== {2'b10, 32'hCAFE_0001}) begin
            n_fail++; $display("FAIL t3_ifu_done: got %b%b %h", m0_rvalid, m1_arready, m0_rdata);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({busy, m1_arready} !== 2'b00) begin n_fail++; $display("FAIL t3_idle: got %b want 00", {busy, m1_arready}); end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({grant_id, m1_arready, s_arvalid, s_araddr} !== {3'b111, 32'h8000_1000}) begin
            n_fail++; $display("FAIL t3_lsu_addr: got %b%b%b %h want 111 80001000", grant_id, m1_arready, s_arvalid, s_araddr);
        end
        next_cycle();
        s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
        @(negedge clk);
        n_checks++;
        if ({m1_rvalid, m0_rvalid, m1_rdata} !== {2'b10, 32'h1234_5678}) begin
            n_fail++; $display("FAIL t3_lsu_data: got %b%b %h", m1_rvalid, m0_rvalid, m1_rdata);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        sel_to = 1'b1;
        m0_araddr = 32'h8000_0040; m0_arvalid = 1'b1; m0_rready = 1'b0; s_arready = 1'b1;
        @(negedge clk); next_cycle();
        @(negedge clk); next_cycle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({to_busy, to_m0_rvalid} !== 2'b10) begin
                n_fail++; $display("FAIL t4_data_wait i=%0d: got %b want 10", i, {to_busy, to_m0_rvalid});
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if ({to_m0_rvalid, to_m1_rvalid, to_s_rready} !== 3'b100) begin
            n_fail++; $display("FAIL t4_err_valid: got %b want 100", {to_m0_rvalid, to_m1_rvalid, to_s_rready});
        end
        n_checks++;
        if ({to_m0_rdata, to_m0_rresp} !== {32'h0, 2'b10}) begin
            n_fail++; $display("FAIL t4_err_resp: got %h/%b want 00000000/10", to_m0_rdata, to_m0_rresp);
        end
        next_cycle();
        m0_rready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({to_m0_rvalid, to_busy} !== 2'b11) begin n_fail++; $display("FAIL t4_err_hold: got %b want 11", {to_m0_rvalid, to_busy}); end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({to_busy, to_m0_rvalid} !== 2'b00) begin n_fail++; $display("FAIL t4_idle: got %b want 00", {to_busy, to_m0_rvalid}); end
        next_cycle();
        s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if ({to_m0_rvalid, to_m1_rvalid, to_s_rready, to_late_drop} !== 4'b0010) begin
            n_fail++; $display("FAIL t4_late_accept: got %b want 0010", {to_m0_rvalid, to_m1_rvalid, to_s_rready, to_late_drop});
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({to_late_drop, to_m0_rvalid} !== 2'b10) begin n_fail++; $display("FAIL t4_late_pulse: got %b want 10", {to_late_drop, to_m0_rvalid}); end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (to_late_drop !== 1'b0) begin n_fail++; $display("FAIL t4_late_once: got %b want 0", to_late_drop); end
        sel_to = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        m1_araddr = 32'h8000_2000; m1_arvalid = 1'b1; m1_rready = 1'b0; s_arready = 1'b1;
        @(negedge clk); next_cycle();
        @(negedge clk); next_cycle();
        s_rvalid = 1'b1; s_rdata = 32'hA5A5_0F0F; s_rresp = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({m1_rvalid, s_rready, m0_rvalid, m1_rdata} !== {3'b100, 32'hA5A5_0F0F}) begin
                n_fail++; $display("FAIL t5_stall i=%0d: got %b%b%b %h", i, m1_rvalid, s_rready, m0_rvalid, m1_rdata);
            end
            next_cycle();
        end
        m1_rready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({m1_rvalid, s_rready, m1_rdata} !== {2'b11, 32'hA5A5_0F0F}) begin
            n_fail++; $display("FAIL t5_release: got %b%b %h", m1_rvalid, s_rready, m1_rdata);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({busy, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL t5_done: got %b want 00", {busy, m1_rvalid}); end
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] v;
        do_reset();
        m0_araddr = 32'h8000_0100; m0_arvalid = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1; s_arready = 1'b1;
        @(negedge clk); next_cycle();
        @(negedge clk); next_cycle();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL t6_in_data: got %b want 1", busy); end
        rst = 1'b1;
        s_rvalid = 1'b1; s_rdata = 32'h0BAD_0BAD;
        #1;
        v = {busy, grant_id, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, late_drop};
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL t6_abort: got %b want 00000000", v); end
        s_rvalid = 1'b0; s_rdata = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m1_araddr = 32'h8000_3000; m1_arvalid = 1'b1;
        @(negedge clk); next_cycle();
        @(negedge clk);
        n_checks++;
        if ({grant_id, s_arvalid, s_araddr} !== {2'b11, 32'h8000_3000}) begin
            n_fail++; $display("FAIL t6_next_addr: got %b%b %h", grant_id, s_arvalid, s_araddr);
        end
        next_cycle();
        s_rvalid = 1'b1; s_rdata = slave_data(32'h8000_3000);
        @(negedge clk);
        n_checks++;
        if ({m1_rvalid, m1_rdata} !== {1'b1, slave_data(32'h8000_3000)}) begin
            n_fail++; $display("FAIL t6_next_data: got %b %h", m1_rvalid, m1_rdata);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [AW-1:0] addr [2];
        logic [AW-1:0] slv_addr;
        int            exp_q [$];
        int            model_last;
        int            who;
        int            budget;
        int            slv_delay;
        bit            slv_busy;
        do_reset();
        model_last = 1;
        slv_busy   = 1'b0;
        slv_delay  = 0;
        slv_addr   = '0;
        for (int r = 0; r < 60; r++) begin
            who     = $urandom_range(1, 3);
            addr[0] = $urandom & 32'hFFFF_FFFC;
            addr[1] = $urandom & 32'hFFFF_FFFC;
            m0_araddr  = addr[0];
            m1_araddr  = addr[1];
            m0_arvalid = (who & 1) != 0;
            m1_arvalid = (who & 2) != 0;
            if (who == 3) begin
                exp_q.push_back(1 - model_last);
                exp_q.push_back(model_last);
            end else begin
                exp_q.push_back(who - 1);
                model_last = who - 1;
            end
            budget = 0;
            while (exp_q.size() > 0 && budget < 100) begin
                s_arready = ($urandom_range(0, 2) != 0);
                m0_rready = ($urandom_range(0, 3) != 0);
                m1_rready = ($urandom_range(0, 3) != 0);
                if (slv_busy && !s_rvalid) begin
                    if (slv_delay == 0) begin
                        s_rvalid = 1'b1;
                        s_rdata  = slave_data(slv_addr);
                        s_rresp  = slave_resp(slv_addr);
                    end else begin
                        slv_delay--;
                    end
                end
                @(negedge clk);
                n_checks++;
                if ((m0_rvalid && m1_rvalid) || (m0_arready && m1_arready)) begin
                    n_fail++; $display("FAIL rnd_exclusive r=%0d: rvalid=%b%b arready=%b%b", r, m0_rvalid, m1_rvalid, m0_arready, m1_arready);
                end
                if (s_arvalid && s_arready) begin
                    n_checks++;
                    if (exp_q.size() == 0 || s_araddr !== addr[exp_q[0]]) begin
                        n_fail++; $display("FAIL rnd_araddr r=%0d: got %h want m%0d", r, s_araddr, (exp_q.size() > 0) ? exp_q[0] : -1);
                    end
                    slv_busy  = 1'b1;
                    slv_addr  = s_araddr;
                    slv_delay = $urandom_range(0, 5);
                end
                if (m0_rvalid && m0_rready) begin
                    n_checks++;
                    if (exp_q.size() == 0 || exp_q[0] != 0 || m0_rdata !== slave_data(addr[0]) || m0_rresp !== slave_resp(addr[0])) begin
                        n_fail++; $display("FAIL rnd_m0_resp r=%0d: got %h/%b want %h/%b", r, m0_rdata, m0_rresp, slave_data(addr[0]), slave_resp(addr[0]));
                    end
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (m1_rvalid && m1_rready) begin
                    n_checks++;
                    if (exp_q.size() == 0 || exp_q[0] != 1 || m1_rdata !== slave_data(addr[1]) || m1_rresp !== slave_resp(addr[1])) begin
                        n_fail++; $display("FAIL rnd_m1_resp r=%0d: got %h/%b want %h/%b", r, m1_rdata, m1_rresp, slave_data(addr[1]), slave_resp(addr[1]));
                    end
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (s_rvalid && s_rready) slv_busy = 1'b0;
                next_cycle();
                budget++;
            end
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++; $display("FAIL rnd_timeout r=%0d: %0d responses outstanding, want 0", r, exp_q.size());
                exp_q.delete();
                do_reset();
                model_last = 1;
                slv_busy   = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_ifu_single();
        test_tie_round_robin();
        test_lsu_waits();
        test_timeout();
        test_backpressure();
        test_reset_mid_data();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
